// File: rtl/datapath_pkg.sv
`default_nettype none
// datapath_pkg: shared encodings, status bit positions and pipeline control structs
// for datapath_pipe.
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VS_C     = 2'b00,
    VS_PC    = 2'b01,
    VS_IMM8  = 2'b10,
    VS_MDATA = 2'b11
  } vsel_e;

  localparam int Z_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;

  // Width-independent control; the top module wraps these with its data fields.
  typedef struct packed {
    shift_e  shift;
    alu_op_e alu_op;
    logic    set_status;
  } ex_ctrl_t;

  typedef struct packed {
    vsel_e vsel;
    logic  wb_en;
  } wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/datapath_pipe_regfile.sv
`default_nettype none
// regfile_p: NREGS x WIDTH register file, two asynchronous read ports,
// one synchronous write port, asynchronous clear.
module regfile_p #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    ra_addr,
  input  logic [RW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule
`default_nettype wire

// File: rtl/datapath_pipe.sv
`default_nettype none
// datapath_pipe: read / execute / writeback pipeline with register-hazard interlock.
// Define DATAPATH_FORWARD_EN to bypass the S2 writeback value into operand read.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 9,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    rs_a,
  input  logic [RW-1:0]    rs_b,
  input  logic [RW-1:0]    rd,
  input  logic [1:0]       shift,
  input  logic [1:0]       alu_op,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       vsel,
  input  logic             wb_en,
  input  logic             set_status,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [PCW-1:0]   pc,
  input  logic [WIDTH-1:0] mdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status
);

  typedef struct packed {
    logic             valid;
    ex_ctrl_t         ex;
    wb_ctrl_t         wb;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm8;
    logic [PCW-1:0]   pc;
  } s1_t;

  typedef struct packed {
    logic             valid;
    wb_ctrl_t         wb;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] imm8;
    logic [PCW-1:0]   pc;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic [WIDTH-1:0] rf_a, rf_b, wb_data, op_a, op_b, b_sh, result;
  logic             ovf, use_a, use_b, s1_hit, wb_fire, accept;

  assign wb_fire = s2.valid && s2.wb.wb_en;
  assign accept  = in_valid && in_ready;

  always_comb begin
    case (s2.wb.vsel)
      VS_C:    wb_data = C;
      VS_PC:   wb_data = {{(WIDTH-PCW){1'b0}}, s2.pc};
      VS_IMM8: wb_data = s2.imm8;
      default: wb_data = mdata;
    endcase
  end

  regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs_a),
    .rb_addr (rs_b),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (wb_fire),
    .waddr   (s2.rd),
    .wdata   (wb_data)
  );

  assign use_a  = !asel;
  assign use_b  = !bsel;
  assign s1_hit = s1.valid && s1.wb.wb_en &&
                  ((use_a && rs_a == s1.rd) || (use_b && rs_b == s1.rd));

`ifdef DATAPATH_FORWARD_EN
  logic fwd_a, fwd_b;
  // The S2 writer commits on the same edge the dependent instruction is accepted.
  assign fwd_a    = wb_fire && rs_a == s2.rd;
  assign fwd_b    = wb_fire && rs_b == s2.rd;
  assign in_ready = !s1_hit;
  assign op_a     = asel ? '0 : (fwd_a ? wb_data : rf_a);
  assign op_b     = bsel ? sximm5 : (fwd_b ? wb_data : rf_b);
`else
  logic s2_hit;
  assign s2_hit   = wb_fire && ((use_a && rs_a == s2.rd) || (use_b && rs_b == s2.rd));
  assign in_ready = !(s1_hit || s2_hit);
  assign op_a     = asel ? '0 : rf_a;
  assign op_b     = bsel ? sximm5 : rf_b;
`endif

  always_comb begin
    case (s1.ex.shift)
      SH_LSL:  b_sh = {s1.b[WIDTH-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, s1.b[WIDTH-1:1]};
      SH_ASR:  b_sh = {s1.b[WIDTH-1], s1.b[WIDTH-1:1]};
      default: b_sh = s1.b;
    endcase
    result = '0;
    ovf    = 1'b0;
    case (s1.ex.alu_op)
      ALU_ADD: begin
        result = s1.a + b_sh;
        ovf    = (s1.a[WIDTH-1] == b_sh[WIDTH-1]) && (result[WIDTH-1] != s1.a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = s1.a - b_sh;
        ovf    = (s1.a[WIDTH-1] != b_sh[WIDTH-1]) && (result[WIDTH-1] != s1.a[WIDTH-1]);
      end
      ALU_AND: result = s1.a & b_sh;
      default: result = ~b_sh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      C      <= '0;
      status <= '0;
    end else begin
      s1.valid <= accept;
      if (accept) begin
        s1.ex.shift      <= shift_e'(shift);
        s1.ex.alu_op     <= alu_op_e'(alu_op);
        s1.ex.set_status <= set_status;
        s1.wb.vsel       <= vsel_e'(vsel);
        s1.wb.wb_en      <= wb_en;
        s1.rd            <= rd;
        s1.a             <= op_a;
        s1.b             <= op_b;
        s1.imm8          <= sximm8;
        s1.pc            <= pc;
      end
      // Bubbles leave C, status and the S2 payload untouched.
      s2.valid <= s1.valid;
      if (s1.valid) begin
        C       <= result;
        s2.wb   <= s1.wb;
        s2.rd   <= s1.rd;
        s2.imm8 <= s1.imm8;
        s2.pc   <= s1.pc;
        if (s1.ex.set_status) begin
          status[Z_BIT] <= (result == '0);
          status[N_BIT] <= result[WIDTH-1];
          status[V_BIT] <= ovf;
        end
      end
    end
  end

  assign out_valid = s2.valid;

endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// tb_datapath_pipe: directed scoreboard bench for a 16-bit/8-reg and a 32-bit/16-reg datapath_pipe.
`timescale 1ns/1ps
module tb_datapath_pipe;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_NOT = 3;
  localparam int SH_NO = 0, SH_L = 1, SH_R = 2, SH_A = 3;
  localparam int V_C = 0, V_PC = 1, V_IMM = 2, V_MD = 3;
`ifdef DATAPATH_FORWARD_EN
  localparam int EXP_DEP_STALLS = 1;
`else
  localparam int EXP_DEP_STALLS = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        v16 = 1'b0, v32 = 1'b0, rdy16, rdy32, ov16, ov32;
  logic [3:0]  rs_a = '0, rs_b = '0, rd = '0;
  logic [1:0]  shift = '0, alu_op = '0, vsel = '0;
  logic        asel = 1'b0, bsel = 1'b0, wb_en = 1'b0, set_status = 1'b0;
  logic [31:0] imm5 = '0, imm8 = '0, mdata = 32'hCAFE_BEEF;
  logic [8:0]  pc = '0;
  logic [15:0] c16;
  logic [31:0] c32;
  logic [2:0]  st16, st32;

  datapath_pipe dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
    .rs_a(rs_a[2:0]), .rs_b(rs_b[2:0]), .rd(rd[2:0]), .shift(shift), .alu_op(alu_op),
    .asel(asel), .bsel(bsel), .vsel(vsel), .wb_en(wb_en), .set_status(set_status),
    .sximm5(imm5[15:0]), .sximm8(imm8[15:0]), .pc(pc), .mdata(mdata[15:0]),
    .out_valid(ov16), .C(c16), .status(st16)
  );

  datapath_pipe #(.WIDTH(32), .NREGS(16), .PCW(9)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .shift(shift), .alu_op(alu_op),
    .asel(asel), .bsel(bsel), .vsel(vsel), .wb_en(wb_en), .set_status(set_status),
    .sximm5(imm5), .sximm8(imm8), .pc(pc), .mdata(mdata),
    .out_valid(ov32), .C(c32), .status(st32)
  );

  typedef struct {
    logic [31:0] c;
    logic [2:0]  st;
    string       name;
  } exp_t;

  exp_t sb16[$];
  exp_t sb32[$];
  exp_t e16, e32;
  int checks = 0;
  int failures = 0;
  int s;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ov16) begin
      if (sb16.size() == 0) begin
        checks++; failures++;
        $display("FAIL out16_unexpected actual=C %h required=no output", c16);
      end else begin
        e16 = sb16.pop_front();
        check({e16.name, "_C"}, {16'b0, c16}, e16.c);
        check({e16.name, "_status"}, {29'b0, st16}, {29'b0, e16.st});
      end
    end
  end

  always @(negedge clk) begin
    if (ov32) begin
      if (sb32.size() == 0) begin
        checks++; failures++;
        $display("FAIL out32_unexpected actual=C %h required=no output", c32);
      end else begin
        e32 = sb32.pop_front();
        check({e32.name, "_C"}, c32, e32.c);
        check({e32.name, "_status"}, {29'b0, st32}, {29'b0, e32.st});
      end
    end
  end

  // Presents the instruction already on the field buses; returns stall cycles seen.
  task automatic issue(input bit big, input string nm, input logic [31:0] ec,
                       input int est, output int stalls);
    exp_t e;
    e.c = ec; e.st = est[2:0]; e.name = nm;
    stalls = 0;
    if (big) v32 = 1'b1; else v16 = 1'b1;
    #1;
    while (!(big ? rdy32 : rdy16) && stalls < 20) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 20) begin
      checks++; failures++;
      $display("FAIL %s_accept actual=in_ready low 20 cycles required=accepted", nm);
    end else begin
      if (big) sb32.push_back(e); else sb16.push_back(e);
      @(negedge clk);
    end
    v16 = 1'b0; v32 = 1'b0;
  endtask

  task automatic alu(input bit big, input string nm, input int ra, input int as_, input int rb,
                     input int bs_, input logic [31:0] i5, input int sh, input int op,
                     input int ss, input int d, input int we, input logic [31:0] ec,
                     input int est, output int stalls);
    rs_a = 4'(ra); asel = as_[0]; rs_b = 4'(rb); bsel = bs_[0]; imm5 = i5;
    shift = 2'(sh); alu_op = 2'(op); set_status = ss[0]; rd = 4'(d); wb_en = we[0];
    vsel = 2'(V_C); imm8 = '0; pc = '0;
    issue(big, nm, ec, est, stalls);
  endtask

  // Writeback-only instruction: ALU computes 0 + 0, status untouched.
  task automatic load(input bit big, input string nm, input int vs, input int d,
                      input logic [31:0] i8, input logic [8:0] p, input int est,
                      output int stalls);
    rs_a = '0; rs_b = '0; asel = 1'b1; bsel = 1'b1; imm5 = '0; shift = '0; alu_op = '0;
    set_status = 1'b0; rd = 4'(d); wb_en = 1'b1; vsel = 2'(vs); imm8 = i8; pc = p;
    issue(big, nm, 32'h0, est, stalls);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    idle(2);
    reset = 1'b0;
    #1;
    check("reset_in_ready16", {31'b0, rdy16}, 1);
    check("reset_out_valid16", {31'b0, ov16}, 0);
    check("reset_C16", {16'b0, c16}, 0);
    check("reset_status16", {29'b0, st16}, 0);
    check("reset_in_ready32", {31'b0, rdy32}, 1);
    check("reset_C32", c32, 0);
    idle(1);

    load(0, "li_r1", V_IMM, 1, 32'h7, 9'h0, 3'b000, s);
    check("li_stalls", 32'(s), 0);
    alu(0, "dep_add", 1, 0, 1, 0, 0, SH_L, OP_ADD, 0, 2, 1, 32'h15, 3'b000, s);
    check("dep_stalls", 32'(s), 32'(EXP_DEP_STALLS));
    idle(3);
    alu(0, "rd_r2", 2, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h15, 3'b000, s);

    load(0, "li_r4", V_IMM, 4, 32'h7FFF, 9'h0, 3'b000, s);
    idle(3);
    alu(0, "ovf_add", 4, 0, 0, 1, 1, SH_NO, OP_ADD, 1, 5, 1, 32'h8000, 3'b011, s);
    alu(0, "ovf_sub", 5, 0, 0, 1, 1, SH_NO, OP_SUB, 1, 0, 0, 32'h7FFF, 3'b001, s);

    load(0, "li_r3", V_IMM, 3, 32'h5, 9'h0, 3'b001, s);
    idle(3);
    alu(0, "zero_sub", 3, 0, 3, 0, 0, SH_NO, OP_SUB, 1, 0, 0, 32'h0, 3'b100, s);
    alu(0, "nostat_add", 4, 0, 0, 1, 1, SH_NO, OP_ADD, 0, 0, 0, 32'h8000, 3'b100, s);
    alu(0, "not_op", 0, 1, 0, 1, 32'h00F0, SH_NO, OP_NOT, 1, 0, 0, 32'hFF0F, 3'b010, s);
    alu(0, "and_lsr", 4, 0, 0, 1, 32'h8000, SH_R, OP_AND, 1, 0, 0, 32'h4000, 3'b000, s);
    alu(0, "asr16", 0, 1, 0, 1, 32'h8002, SH_A, OP_ADD, 1, 0, 0, 32'hC001, 3'b010, s);

    load(0, "li_pc", V_PC, 6, 32'h0, 9'h1AB, 3'b010, s);
    load(0, "li_md", V_MD, 7, 32'h0, 9'h0, 3'b010, s);
    idle(3);
    alu(0, "rd_r6", 6, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h01AB, 3'b010, s);
    alu(0, "rd_r7", 7, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'hBEEF, 3'b010, s);
    alu(0, "self_src", 3, 0, 0, 1, 1, SH_NO, OP_ADD, 0, 3, 1, 32'h6, 3'b010, s);
    idle(3);
    alu(0, "rd_r3", 3, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h6, 3'b010, s);
    idle(3);

    // Reset lands while the writeback of li_rst is still in flight.
    load(0, "li_rst", V_IMM, 6, 32'h55, 9'h0, 3'b010, s);
    reset = 1'b1;
    sb16.delete();
    sb32.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, ov16}, 0);
    check("rst_in_ready", {31'b0, rdy16}, 1);
    check("rst_C", {16'b0, c16}, 0);
    @(negedge clk); #1;
    check("rst_out_valid_late", {31'b0, ov16}, 0);
    idle(2);
    alu(0, "rd_r6_rst", 6, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h0, 3'b000, s);

    load(1, "li_r15", V_IMM, 15, 32'h1234_5678, 9'h0, 3'b000, s);
    alu(1, "asr32", 0, 1, 0, 1, 32'h8000_0000, SH_A, OP_ADD, 1, 0, 0, 32'hC000_0000, 3'b010, s);
    load(1, "li_pc32", V_PC, 14, 32'h0, 9'h1FF, 3'b010, s);
    idle(3);
    alu(1, "rd_r15", 15, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h1234_5678, 3'b010, s);
    alu(1, "rd_r7_32", 7, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h0, 3'b010, s);
    alu(1, "rd_r14_32", 14, 0, 0, 1, 0, SH_NO, OP_ADD, 0, 0, 0, 32'h1FF, 3'b010, s);

    idle(5);
    check("sb16_drained", 32'(sb16.size()), 0);
    check("sb32_drained", 32'(sb32.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
